future_round_ctrl: RTL and testbench

Iterative round controller for the FUTURE-family 64-bit block datapath. It accepts one plaintext block and a 128-bit key through a valid/ready handshake. It then sequences the state through NR rounds, one round per clock, using four copies of the 16-bit column mix. Finally it presents the whitened ciphertext through a second valid/ready handshake. It sits between the host data interface and the combinational column-mix layer and is the single owner of that layer.

---
 rtl/future_pkg.sv | 47 ++++
 rtl/future_col_mix.sv | 14 +
 rtl/future_round_ctrl.sv | 123 ++++++++++++
 tb/tb_future_round_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/future_pkg.sv
// Shared widths, FSM state type, S-box table and round-key helper for the FUTURE 64-bit block datapath.
package future_pkg;

  localparam int BLK_W  = 64;
  localparam int KEY_W  = 128;
  localparam int COL_W  = 16;
  localparam int N_COLS = BLK_W / COL_W;
  localparam int RND_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [BLK_W-1:0] blk_t;
  typedef logic [KEY_W-1:0] key_t;
  typedef logic [RND_W-1:0] rnd_t;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic blk_t sub_nibbles(input blk_t s);
    blk_t o;
    for (int i = 0; i < BLK_W / 4; i++) begin
      o[4*i +: 4] = sbox4(s[4*i +: 4]);
    end
    return o;
  endfunction

  // Even rounds take the upper key half, odd rounds the lower; the round index
  // plus one (mod 16) is folded into the low nibble.
  function automatic blk_t round_key(input key_t k, input rnd_t r);
    blk_t base;
    rnd_t tag;
    base = r[0] ? k[63:0] : k[127:64];
    tag  = r + rnd_t'(1);
    return base ^ {{(BLK_W - RND_W){1'b0}}, tag};
  endfunction

endpackage

// File: rtl/future_col_mix.sv
// Combinational 16-bit column mix; zero latency, no flow control.
module future_col_mix
  import future_pkg::*;
(
  input  logic [COL_W-1:0] b_dat,
  output logic [COL_W-1:0] c_dat
);

  assign c_dat[3:0]   = b_dat[15:12] ^ b_dat[11:8];
  assign c_dat[7:4]   = b_dat[3:0];
  assign c_dat[11:8]  = b_dat[3:0] ^ b_dat[7:4];
  assign c_dat[15:12] = b_dat[11:8];

endmodule

// File: rtl/future_round_ctrl.sv
// Iterative FUTURE round controller: one round per clock, out_valid NR cycles after accept; output held while out_ready is low.
// Define FUTURE_SBOX_EN to insert the 4-bit S-box layer ahead of the column mix.
module future_round_ctrl
  import future_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] pt,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] ct,
  output logic             busy
);

  localparam rnd_t LAST_RND  = rnd_t'(NR - 1);
  localparam rnd_t FINAL_IDX = rnd_t'(NR);

  state_e state_q, state_d;
  blk_t   s_q, s_d;
  key_t   key_q, key_d;
  rnd_t   rnd_q, rnd_d;

  blk_t   pre_sb;
  blk_t   sb_out;
  blk_t   mix_out;
  blk_t   round_out;
  logic   last_rnd;

  assign pre_sb = s_q ^ round_key(key_q, rnd_q);

`ifdef FUTURE_SBOX_EN
  assign sb_out = sub_nibbles(pre_sb);
`else
  assign sb_out = pre_sb;
`endif

  for (genvar j = 0; j < N_COLS; j++) begin : g_col
    future_col_mix u_col_mix (
      .b_dat(sb_out[COL_W*j +: COL_W]),
      .c_dat(mix_out[COL_W*j +: COL_W])
    );
  end

  // Output whitening is merged into the last round so DONE needs no extra cycle.
  assign last_rnd  = (rnd_q == LAST_RND);
  assign round_out = last_rnd ? (mix_out ^ round_key(key_q, FINAL_IDX)) : mix_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ROUND;
          s_d     = pt;
          key_d   = key;
          rnd_d   = '0;
        end
      end
      ROUND: begin
        s_d   = round_out;
        rnd_d = rnd_q + rnd_t'(1);
        if (last_rnd) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs depend only on registered state (and reset), never on in_valid/out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
      end
      ROUND: begin
        busy = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign ct = s_q;

endmodule

// File: tb/tb_future_round_ctrl.sv
// Randomised bench for future_round_ctrl (NR=10 and NR=1 instances) against a round-by-round reference model.
module tb_future_round_ctrl;

  localparam int NR  = 10;
  localparam int NR1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]  pt, ct;
  logic [127:0] key;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [63:0]  pt1, ct1;
  logic [127:0] key1;

  logic [15:0]  cm_in, cm_out;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  future_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pt(pt), .key(key),
    .out_valid(out_valid), .out_ready(out_ready), .ct(ct), .busy(busy)
  );

  future_round_ctrl #(.NR(NR1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .pt(pt1), .key(key1),
    .out_valid(out_valid1), .out_ready(out_ready1), .ct(ct1), .busy(busy1)
  );

  future_col_mix u_cm (.b_dat(cm_in), .c_dat(cm_out));

`ifdef FUTURE_SBOX_EN
  localparam logic [3:0] SB_TAB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
`endif

  function automatic logic [15:0] ref_mix(input logic [15:0] b);
    logic [3:0] n0, n1, n2, n3;
    n0 = b[3:0]; n1 = b[7:4]; n2 = b[11:8]; n3 = b[15:12];
    return {n2, n0 ^ n1, n0, n3 ^ n2};
  endfunction

  function automatic logic [63:0] model(input logic [63:0] p, input logic [127:0] k, input int nr);
    logic [63:0] s, rk;
    s = p;
    for (int r = 0; r <= nr; r++) begin
      rk = (r % 2 == 0) ? k[127:64] : k[63:0];
      rk[3:0] = rk[3:0] ^ 4'((r + 1) % 16);
      s = s ^ rk;
      if (r < nr) begin
`ifdef FUTURE_SBOX_EN
        for (int i = 0; i < 16; i++) s[4*i +: 4] = SB_TAB[s[4*i +: 4]];
`endif
        for (int j = 0; j < 4; j++) s[16*j +: 16] = ref_mix(s[16*j +: 16]);
      end
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] p, input logic [127:0] k);
    int w;
    pt = p; key = k; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    n_chk++; if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", in_ready, w); else n_pass++;
    tick();
    in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin tick(); k++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; out_ready = 0; pt = '0; key = '0;
    in_valid1 = 0; out_ready1 = 0; pt1 = '0; key1 = '0; cm_in = '0;
    repeat (3) tick();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_chk++; if (ct !== 64'h0) $display("FAIL rst_ct: got %h, required 0", ct); else n_pass++;
    n_chk++; if (ct1 !== 64'h0) $display("FAIL rst_ct1: got %h, required 0", ct1); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b, required 1", in_ready); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rel_out_valid: got %b, required 0", out_valid); else n_pass++;
  endtask

  task automatic test_col_mix();
    logic [15:0] vin [3];
    logic [15:0] vexp [3];
    vin[0] = 16'h0001; vexp[0] = 16'h0110;
    vin[1] = 16'h1000; vexp[1] = 16'h0001;
    vin[2] = 16'h0100; vexp[2] = 16'h1001;
    for (int i = 0; i < 3; i++) begin
      cm_in = vin[i]; #1;
      n_chk++; if (cm_out !== vexp[i]) $display("FAIL col_mix_vec%0d: got %h, required %h", i, cm_out, vexp[i]); else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      cm_in = 16'($urandom); #1;
      n_chk++; if (cm_out !== ref_mix(cm_in)) $display("FAIL col_mix_rand: in %h got %h, required %h", cm_in, cm_out, ref_mix(cm_in)); else n_pass++;
    end
  endtask

  task automatic test_nr1();
    logic [63:0]  p;
    logic [127:0] k;
    for (int i = 0; i < 21; i++) begin
      p = (i == 0) ? 64'h0 : {$urandom, $urandom};
      k = (i == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
      n_chk++; if (in_ready1 !== 1'b1) $display("FAIL nr1_in_ready: got %b, required 1", in_ready1); else n_pass++;
      pt1 = p; key1 = k; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      n_chk++; if (out_valid1 !== 1'b0) $display("FAIL nr1_early_valid: got %b, required 0", out_valid1); else n_pass++;
      tick();
      n_chk++; if (out_valid1 !== 1'b1) $display("FAIL nr1_valid: got %b, required 1", out_valid1); else n_pass++;
      if (i == 0) begin
        n_chk++; if (ct1 !== 64'h0000_0000_0000_0112) $display("FAIL nr1_zero_ct: got %h, required 0000000000000112", ct1); else n_pass++;
      end else begin
        n_chk++; if (ct1 !== model(p, k, NR1)) $display("FAIL nr1_ct: got %h, required %h", ct1, model(p, k, NR1)); else n_pass++;
      end
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
    end
  endtask

  task automatic test_latency();
    logic [63:0]  p;
    logic [127:0] k;
    int lat;
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    send(p, k);
    n_chk++; if (busy !== 1'b1) $display("FAIL lat_busy: got %b, required 1", busy); else n_pass++;
    wait_out(lat);
    n_chk++; if (lat !== NR) $display("FAIL lat_cycles: got %0d, required %0d", lat, NR); else n_pass++;
    n_chk++; if (ct !== model(p, k, NR)) $display("FAIL lat_ct: got %h, required %h", ct, model(p, k, NR)); else n_pass++;
    handshake();
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL lat_idle: out_valid=%b busy=%b, required 0/0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0]  p, c0;
    logic [127:0] k;
    int lat;
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    send(p, k);
    wait_out(lat);
    c0 = ct;
    n_chk++; if (c0 !== model(p, k, NR)) $display("FAIL bp_ct: got %h, required %h", c0, model(p, k, NR)); else n_pass++;
    repeat (7) begin
      tick();
      n_chk++; if (ct !== c0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold: ct=%h valid=%b in_ready=%b, required %h/1/0", ct, out_valid, in_ready, c0); else n_pass++;
    end
    handshake();
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release: in_ready=%b valid=%b, required 1/0", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_isolation();
    logic [63:0]  p;
    logic [127:0] k;
    int lat;
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    send(p, k);
    repeat (NR - 1) begin
      pt = {$urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_out(lat);
    n_chk++; if (ct !== model(p, k, NR)) $display("FAIL iso_ct: got %h, required %h", ct, model(p, k, NR)); else n_pass++;
    handshake();
  endtask

  task automatic test_simultaneous();
    logic [63:0]  p, p2;
    logic [127:0] k, k2;
    int lat;
    p  = {$urandom, $urandom}; k  = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom}; k2 = {$urandom, $urandom, $urandom, $urandom};
    send(p, k);
    wait_out(lat);
    n_chk++; if (ct !== model(p, k, NR)) $display("FAIL sim_ct1: got %h, required %h", ct, model(p, k, NR)); else n_pass++;
    pt = p2; key = k2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL sim_no_accept: busy=%b in_ready=%b, required 0/1", busy, in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL sim_accept: busy=%b, required 1", busy); else n_pass++;
    wait_out(lat);
    n_chk++; if (ct !== model(p2, k2, NR)) $display("FAIL sim_ct2: got %h, required %h", ct, model(p2, k2, NR)); else n_pass++;
    handshake();
  endtask

  task automatic test_mid_reset();
    logic [63:0]  p;
    logic [127:0] k;
    int lat;
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    send(p, k);
    repeat (5) tick();
    n_chk++; if (busy !== 1'b1) $display("FAIL mr_busy_before: got %b, required 1", busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0 || ct !== 64'h0 || in_ready !== 1'b0)
      $display("FAIL mr_async: valid=%b busy=%b ct=%h in_ready=%b, required 0/0/0/0", out_valid, busy, ct, in_ready); else n_pass++;
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL mr_release: in_ready=%b valid=%b, required 1/0", in_ready, out_valid); else n_pass++;
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    send(p, k);
    wait_out(lat);
    n_chk++; if (lat !== NR) $display("FAIL mr_lat: got %0d, required %0d", lat, NR); else n_pass++;
    n_chk++; if (ct !== model(p, k, NR)) $display("FAIL mr_ct: got %h, required %h", ct, model(p, k, NR)); else n_pass++;
    handshake();
  endtask

  task automatic test_stream(input int nblk);
    logic [63:0]  p, exp_ct;
    logic [127:0] k;
    int stall, prev_stall, prev_acc, lat;
    prev_stall = 1;
    prev_acc = 0;
    for (int i = 0; i < nblk; i++) begin
      p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      exp_ct = model(p, k, NR);
      send(p, k);
      if (i > 0 && prev_stall == 0) begin
        n_chk++; if (last_acc - prev_acc !== NR + 2) $display("FAIL stream_rate: blk %0d interval %0d, required %0d", i, last_acc - prev_acc, NR + 2); else n_pass++;
      end
      prev_acc = last_acc;
      prev_stall = stall;
      wait_out(lat);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL stream_timeout: blk %0d out_valid=%b, required 1", i, out_valid); else n_pass++;
      for (int s = 0; s < stall; s++) begin
        tick();
        n_chk++; if (ct !== exp_ct || out_valid !== 1'b1) $display("FAIL stream_stall: blk %0d ct=%h valid=%b, required %h/1", i, ct, out_valid, exp_ct); else n_pass++;
      end
      n_chk++; if (ct !== exp_ct) $display("FAIL stream_ct: blk %0d got %h, required %h", i, ct, exp_ct); else n_pass++;
      handshake();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_col_mix();
    test_nr1();
    test_latency();
    test_backpressure();
    test_isolation();
    test_simultaneous();
    test_mid_reset();
    test_stream(1000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
